sram_fifo_reader: RTL and testbench



---
 rtl/sram_fifo_pkg.sv | 20 ++
 rtl/sram_fifo_skid_buf.sv | 79 +++++++
 rtl/sram_fifo_reader.sv | 96 +++++++++
 tb/tb_sram_fifo_reader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_fifo_pkg.sv
// rtl/sram_fifo_pkg.sv - shared constants and sizing helpers for the sram fifo reader
// Purpose: default read latency plus the skid-buffer depth and count-width
//          helpers used by sram_fifo_reader and sram_fifo_skid_buf.
// Ports:   none (package).
package sram_fifo_pkg;

  localparam int READ_LATENCY_DEFAULT = 1;

  // One slot per word that can be in flight plus one for the word being
  // presented downstream, so streaming never stalls.
  function automatic int buf_depth(input int lat);
    return lat + 1;
  endfunction

  // Width needed to hold counts 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sram_fifo_skid_buf.sv
// rtl/sram_fifo_skid_buf.sv - circular skid buffer holding words returned by the fifo
// Purpose: DEPTH-entry circular buffer with push, pop, flush and a count.
//          Storage is reset and the head is read straight from the storage
//          flops, so data_o never bypasses from push_data_i.
// Ports:   clk_i, rst_i (async, active high), flush_i (clears pointers/count),
//          push_i/push_data_i (write at tail), pop_i (advance head),
//          data_o (head word), cnt_o (words held).
module sram_fifo_skid_buf
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int CNT_W      = cnt_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CNT_W-1:0]      cnt_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_data_i;
    end
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_i) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop_i)  rd_ptr_d = next_ptr(rd_ptr_q);
      // Simultaneous push and pop leaves the count unchanged.
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign data_o = mem_q[rd_ptr_q];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/sram_fifo_reader.sv
// rtl/sram_fifo_reader.sv - read-side adapter absorbing the BRAM fifo read latency
// Purpose: issues pops to the fifo only when every returning word is sure of
//          a skid-buffer slot, tracks in-flight pops, and presents captured
//          words on a valid/ready stream at full throughput.
// Ports:   clk_i, rst_i (async, active high), flush_i (sync flush),
//          fifo_empty_i/fifo_data_i/fifo_pop_o (fifo read port),
//          valid_o/ready_i/data_o (downstream stream),
//          occupancy_o (buffered plus in-flight words).
module sram_fifo_reader
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = READ_LATENCY_DEFAULT,
  parameter int BUF_DEPTH    = buf_depth(READ_LATENCY)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic                           fifo_empty_i,
  input  logic [DATA_WIDTH-1:0]          fifo_data_i,
  output logic                           fifo_pop_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [DATA_WIDTH-1:0]          data_o,
  output logic [$clog2(BUF_DEPTH+1)-1:0] occupancy_o
);

  localparam int CNT_W = cnt_width(BUF_DEPTH);

  logic [READ_LATENCY-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0]        buf_cnt;
  logic [CNT_W-1:0]        inflight_cnt;
  logic [CNT_W-1:0]        occ;
  logic [CNT_W:0]          occ_ext, limit_ext;
  logic                    deq, pop, capture;

  assign deq = valid_o && ready_i;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + CNT_W'(inflight_q[i]);
    end
  end

  assign occ = buf_cnt + inflight_cnt;

  // occ - deq < BUF_DEPTH, rearranged to avoid underflow. The dequeue term
  // makes ready_i -> fifo_pop_o combinational, which is what keeps one pop
  // per cycle while streaming.
  assign occ_ext   = {1'b0, occ};
  assign limit_ext = (CNT_W + 1)'(BUF_DEPTH) + {{CNT_W{1'b0}}, deq};
  assign pop       = !rst_i && !flush_i && !fifo_empty_i && (occ_ext < limit_ext);

  // Bit 0 records this cycle's pop; the top bit marks fifo_data_i valid now.
  always_comb begin
    inflight_d = '0;
    if (!flush_i) begin
      inflight_d[0] = pop;
      for (int i = 1; i < READ_LATENCY; i++) begin
        inflight_d[i] = inflight_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  // A word landing in the flush cycle belongs to a pre-flush pop: drop it.
  assign capture = inflight_q[READ_LATENCY-1] && !flush_i;

  sram_fifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH),
    .CNT_W      (CNT_W)
  ) u_skid_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .push_i      (capture),
    .push_data_i (fifo_data_i),
    .pop_i       (deq),
    .data_o      (data_o),
    .cnt_o       (buf_cnt)
  );

  assign fifo_pop_o  = pop;
  assign valid_o     = (buf_cnt != '0);
  assign occupancy_o = occ;

endmodule

// File: tb/tb_sram_fifo_reader.sv
// tb/tb_sram_fifo_reader.sv - scoreboard bench for sram_fifo_reader at read latencies 1, 2 and 3
module tb_sram_fifo_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush [3];
  logic        empty [3];
  logic        pop   [3];
  logic        valid [3];
  logic        ready [3];
  logic [31:0] fdata [3];
  logic [31:0] dout  [3];
  logic [1:0]  occ0, occ1;
  logic [2:0]  occ2;
  logic [2:0]  occ_w [3];

  // Behavioural BRAM fifo per instance: storage, counters, read pipeline.
  logic [31:0] fmem   [3][0:127];
  int          wr_cnt [3];
  int          rd_cnt [3];
  logic [31:0] pipe_d [3][3];

  logic [31:0] exp_q [3][$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  assign occ_w[0] = {1'b0, occ0};
  assign occ_w[1] = {1'b0, occ1};
  assign occ_w[2] = occ2;

  for (genvar g = 0; g < 3; g++) begin : g_model
    assign empty[g] = (rd_cnt[g] == wr_cnt[g]);
    assign fdata[g] = pipe_d[g][g];
  end

  sram_fifo_reader #(.DATA_WIDTH(32), .READ_LATENCY(1)) u_lat1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[0]), .fifo_empty_i(empty[0]),
    .fifo_data_i(fdata[0]), .fifo_pop_o(pop[0]), .valid_o(valid[0]),
    .ready_i(ready[0]), .data_o(dout[0]), .occupancy_o(occ0));

  sram_fifo_reader #(.DATA_WIDTH(32), .READ_LATENCY(2)) u_lat2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[1]), .fifo_empty_i(empty[1]),
    .fifo_data_i(fdata[1]), .fifo_pop_o(pop[1]), .valid_o(valid[1]),
    .ready_i(ready[1]), .data_o(dout[1]), .occupancy_o(occ1));

  sram_fifo_reader #(.DATA_WIDTH(32), .READ_LATENCY(3)) u_lat3 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[2]), .fifo_empty_i(empty[2]),
    .fifo_data_i(fdata[2]), .fifo_pop_o(pop[2]), .valid_o(valid[2]),
    .ready_i(ready[2]), .data_o(dout[2]), .occupancy_o(occ2));

  // Fifo model: a flush or reset discards unread words but not the read
  // pipeline, so data for pre-flush pops still returns.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst || flush[i]) rd_cnt[i] <= wr_cnt[i];
      else if (pop[i])     rd_cnt[i] <= rd_cnt[i] + 1;
      pipe_d[i][0] <= (pop[i] && !rst) ? fmem[i][rd_cnt[i] % 128] : 32'hDEAD_BEEF;
      for (int k = 1; k < 3; k++) begin
        pipe_d[i][k] <= rst ? 32'hDEAD_BEEF : pipe_d[i][k-1];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
    end
  endtask

  task automatic load(input int i, input logic [31:0] w, input bit keep);
    fmem[i][wr_cnt[i] % 128] = w;
    wr_cnt[i] = wr_cnt[i] + 1;
    if (keep) exp_q[i].push_back(w);
  endtask

  task automatic drain(input int i, input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (exp_q[i].size() != 0 && n < budget);
    chk("drain_left", exp_q[i].size(), 0);
  endtask

  // Monitor: pops the scoreboard on each handshake, checks hold stability
  // under back-pressure and that no pop is issued into an empty fifo.
  initial begin
    logic        held   [3];
    logic [31:0] held_d [3];
    for (int i = 0; i < 3; i++) begin
      held[i]   = 1'b0;
      held_d[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          held[i] = 1'b0;
        end else begin
          if (pop[i]) chk("pop_while_empty", empty[i], 0);
          if (held[i]) begin
            chk("hold_valid", valid[i], 1);
            chk("hold_data", dout[i], held_d[i]);
          end
          if (valid[i] && ready[i]) begin
            if (exp_q[i].size() == 0) chk("extra_word", exp_q[i].size(), 1);
            else chk("data", dout[i], exp_q[i].pop_front());
          end
          held[i]   = valid[i] && !ready[i] && !flush[i];
          held_d[i] = dout[i];
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [17:0] pv, vv;
    logic [2:0]  occ6, maxocc;
    int          k;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flush[i]  = 1'b0;
      ready[i]  = 1'b0;
      wr_cnt[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_pop", pop[i], 0);
      chk("rst_valid", valid[i], 0);
      chk("rst_data", dout[i], 0);
      chk("rst_occ", occ_w[i], 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Streaming, latency 1: pops cycles 0..7, words out cycles 2..9.
    ready[0] = 1'b1;
    for (int w = 'h11; w <= 'h18; w++) load(0, 32'(w), 1'b1);
    pv = '0; vv = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      pv[c] = pop[0];
      vv[c] = valid[0];
    end
    chk("stream_pop_cycles", {20'd0, pv[11:0]}, 32'h0FF);
    chk("stream_valid_cycles", {20'd0, vv[11:0]}, 32'h3FC);
    drain(0, 20);

    // Back-pressure, latency 1: ready low for cycles 3..9.
    pv = '0; vv = '0; occ6 = '0; maxocc = '0;
    for (int c = 0; c < 18; c++) begin
      ready[0] = !(c >= 3 && c <= 9);
      if (c == 0) for (int w = 'h21; w <= 'h28; w++) load(0, 32'(w), 1'b1);
      @(negedge clk);
      pv[c] = pop[0];
      vv[c] = valid[0];
      if (occ_w[0] > maxocc) maxocc = occ_w[0];
      if (c == 6) occ6 = occ_w[0];
      @(posedge clk); #1;
    end
    chk("bp_pop_cycles", {14'd0, pv}, 32'h07C07);
    chk("bp_valid_cycles", {14'd0, vv}, 32'h1FFFC);
    chk("bp_occ_saturated", occ6, 2);
    chk("bp_occ_max", maxocc, 2);
    ready[0] = 1'b1;
    drain(0, 20);

    // Latency 3, ready toggling.
    maxocc = '0;
    for (int w = 1; w <= 10; w++) load(2, 32'(w), 1'b1);
    k = 0;
    while (exp_q[2].size() != 0 && k < 200) begin
      ready[2] = (k % 2 == 0);
      @(negedge clk);
      if (occ_w[2] > maxocc) maxocc = occ_w[2];
      @(posedge clk); #1;
      k++;
    end
    chk("lat3_drained", exp_q[2].size(), 0);
    chk("lat3_occ_le4", {31'd0, maxocc <= 3'd4}, 1);
    chk("lat3_final_occ", occ_w[2], 0);

    // Flush one cycle after a pop with two words buffered (latency 1).
    for (int c = 0; c < 7; c++) begin
      ready[0] = (c == 3 || c == 4);
      flush[0] = (c == 4);
      if (c == 0) begin
        load(0, 32'h31, 1'b1);
        load(0, 32'h32, 1'b1);
        load(0, 32'h33, 1'b0);
        load(0, 32'h34, 1'b0);
      end
      @(negedge clk);
      if (c == 2) chk("fl_occ_before", occ_w[0], 2);
      if (c == 3) chk("fl_pop_before", pop[0], 1);
      if (c == 4) chk("fl_no_pop", pop[0], 0);
      if (c >= 5) begin
        chk("fl_valid_after", valid[0], 0);
        chk("fl_occ_after", occ_w[0], 0);
      end
      @(posedge clk); #1;
    end
    flush[0] = 1'b0;
    drain(0, 5);

    // Asynchronous reset mid-stream.
    ready[0] = 1'b1;
    for (int w = 'h41; w <= 'h48; w++) load(0, 32'(w), (w <= 'h42));
    repeat (4) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_valid", valid[0], 0);
    chk("mrst_pop", pop[0], 0);
    chk("mrst_occ", occ_w[0], 0);
    chk("mrst_data", dout[0], 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int w = 'h51; w <= 'h53; w++) load(0, 32'(w), 1'b1);
    drain(0, 20);

    // Wrap-around, latency 2 (depth 3), random data and ready.
    maxocc = '0;
    for (int w = 0; w < 100; w++) load(1, $urandom, 1'b1);
    k = 0;
    while (exp_q[1].size() != 0 && k < 3000) begin
      ready[1] = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (occ_w[1] > maxocc) maxocc = occ_w[1];
      @(posedge clk); #1;
      k++;
    end
    chk("wrap_drained", exp_q[1].size(), 0);
    chk("wrap_occ_le3", {31'd0, maxocc <= 3'd3}, 1);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk("final_valid", valid[i], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
